approx_adder_error_monitor: RTL and testbench

Windowed error-metric collector downstream of the approximate 16-bit adders. Each accepted sample carries the two operands, the carry-in and the approximate adder's result. The block recomputes the exact sum and measures the error distance ED = |exact − approx|. Over a window of 2^window_log2 samples it accumulates the error count, maximum ED and sum of ED, then publishes the three metrics with a one-cycle done pulse. It sits between the adder under test and the characterisation bench/readout logic.

---
 rtl/approx_adder_error_monitor_pkg.sv | 24 ++
 rtl/approx_adder_error_monitor_if.sv | 29 ++
 rtl/approx_adder_error_monitor_cla.sv | 26 ++
 rtl/approx_adder_error_monitor.sv | 151 +++++++++++++++
 tb/tb_approx_adder_error_monitor.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_adder_error_monitor_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
package approx_metrics_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_e;

  // S1 and S2 must empty before the accumulators are final.
  localparam int DRAIN_CYCLES = 2;

  // Error distance between two (width+1)-bit results.
  function automatic int ed_w(input int width);
    return width + 1;
  endfunction

  // Sum of a full window of maximal ED cannot overflow.
  function automatic int sum_w(input int width, input int window_log2);
    return width + 1 + window_log2;
  endfunction

  // Holds 0 .. 2^window_log2 without wrap.
  function automatic int cnt_w(input int window_log2);
    return window_log2 + 1;
  endfunction

endpackage

// File: rtl/approx_adder_error_monitor_if.sv
// Sample/metric bus between the adder under test, the monitor and readout.
interface approx_adder_error_monitor_if
  import approx_metrics_pkg::*;
#(
  parameter int width       = 16,
  parameter int window_log2 = 8
) ();
  logic                                   start_i;
  logic                                   valid_i;
  logic [width-1:0]                       add1_i;
  logic [width-1:0]                       add2_i;
  logic                                   carry_i;
  logic [ed_w(width)-1:0]                 approx_i;
  logic                                   busy_o;
  logic                                   done_o;
  logic [cnt_w(window_log2)-1:0]          err_count_o;
  logic [ed_w(width)-1:0]                 max_ed_o;
  logic [sum_w(width, window_log2)-1:0]   sum_ed_o;

  modport master (
    output start_i, valid_i, add1_i, add2_i, carry_i, approx_i,
    input  busy_o, done_o, err_count_o, max_ed_o, sum_ed_o
  );

  modport slave (
    input  start_i, valid_i, add1_i, add2_i, carry_i, approx_i,
    output busy_o, done_o, err_count_o, max_ed_o, sum_ed_o
  );
endinterface

// File: rtl/approx_adder_error_monitor_cla.sv
// Exact golden adder: generate/propagate carry chain, result {cout, sum}.
module carry_lookahead_adder #(
  parameter int width = 16
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             c_i,
  output logic [width:0]   result_o
);
  logic [width-1:0] w_g;
  logic [width-1:0] w_p;
  logic [width:0]   w_c;

  assign w_g = a_i & b_i;
  assign w_p = a_i ^ b_i;

  // Carry into each bit from generate/propagate terms.
  always_comb begin
    w_c    = '0;
    w_c[0] = c_i;
    for (int i = 0; i < width; i++)
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
  end

  assign result_o = {w_c[width], w_p ^ w_c[width-1:0]};
endmodule

// File: rtl/approx_adder_error_monitor.sv
// Windowed error-metric collector: exact vs approximate sum, ED count/max/sum.
module approx_adder_error_monitor
  import approx_metrics_pkg::*;
#(
  parameter int width       = 16,
  parameter int window_log2 = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  approx_adder_error_monitor_if.slave   bus
);
  localparam int EW = ed_w(width);
  localparam int SW = sum_w(width, window_log2);
  localparam int CW = cnt_w(window_log2);
  localparam logic [CW-1:0] LAST = CW'((1 << window_log2) - 1);

  state_e          r_state, w_next;
  logic [1:0]      r_drain;
  logic [CW-1:0]   r_cnt;
  logic            r_done;

  logic            r_s1_vld;
  logic [width-1:0] r_s1_a, r_s1_b;
  logic            r_s1_c;
  logic [EW-1:0]   r_s1_ap;
  logic [EW-1:0]   w_exact;
  logic [EW-1:0]   w_ed;

  logic            r_s2_vld;
  logic [EW-1:0]   r_s2_ed;

  logic [CW-1:0]   r_acc_cnt;
  logic [EW-1:0]   r_acc_max;
  logic [SW-1:0]   r_acc_sum;

  logic [CW-1:0]   r_out_cnt;
  logic [EW-1:0]   r_out_max;
  logic [SW-1:0]   r_out_sum;

  logic w_acc, w_clr;

  // A start while done_o is still high is ignored, so back-to-back windows
  // begin at the earliest one cycle after the pulse.
  assign w_acc = (r_state == COLLECT) && bus.valid_i;
  assign w_clr = (r_state == IDLE) && bus.start_i && !r_done;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_clr) w_next = COLLECT;
      COLLECT: if (w_acc && r_cnt == LAST) w_next = DRAIN;
      DRAIN:   if (r_drain == 2'(DRAIN_CYCLES - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Drain cycle counter and window sample counter.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_drain <= '0;
      r_cnt   <= '0;
    end else begin
      r_drain <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
      if (w_clr)      r_cnt <= '0;
      else if (w_acc) r_cnt <= r_cnt + CW'(1);
    end

  // S1: capture the accepted sample.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_s1_vld <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_c   <= 1'b0;
      r_s1_ap  <= '0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_a  <= bus.add1_i;
        r_s1_b  <= bus.add2_i;
        r_s1_c  <= bus.carry_i;
        r_s1_ap <= bus.approx_i;
      end
    end

  carry_lookahead_adder #(.width(width)) u_gold (
    .a_i      (r_s1_a),
    .b_i      (r_s1_b),
    .c_i      (r_s1_c),
    .result_o (w_exact)
  );

  // Larger minus smaller, never wraps.
  assign w_ed = (w_exact >= r_s1_ap) ? (w_exact - r_s1_ap) : (r_s1_ap - w_exact);

  // S2: register the error distance.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_s2_vld <= 1'b0;
      r_s2_ed  <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_s2_ed  <= w_ed;
    end

  // Accumulate metrics of the current window; cleared on start.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_acc_cnt <= '0;
      r_acc_max <= '0;
      r_acc_sum <= '0;
    end else if (w_clr) begin
      r_acc_cnt <= '0;
      r_acc_max <= '0;
      r_acc_sum <= '0;
    end else if (r_s2_vld) begin
      if (r_s2_ed != '0)       r_acc_cnt <= r_acc_cnt + CW'(1);
      if (r_s2_ed > r_acc_max) r_acc_max <= r_s2_ed;
      r_acc_sum <= r_acc_sum + SW'(r_s2_ed);
    end

  // Publish on DONE; outputs hold until the next window completes.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_out_cnt <= '0;
      r_out_max <= '0;
      r_out_sum <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_out_cnt <= r_acc_cnt;
        r_out_max <= r_acc_max;
        r_out_sum <= r_acc_sum;
      end
    end

  // busy stays up through DONE and drops together with the done pulse.
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.done_o      = r_done;
  assign bus.err_count_o = r_out_cnt;
  assign bus.max_ed_o    = r_out_max;
  assign bus.sum_ed_o    = r_out_sum;
endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Bench for approx_adder_error_monitor with width=16, window_log2=2.
module tb_approx_adder_error_monitor;
  localparam int W  = 16;
  localparam int WL = 2;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  approx_adder_error_monitor_if #(.width(W), .window_log2(WL)) bus ();

  approx_adder_error_monitor #(.width(W), .window_log2(WL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] s_a [N];
  logic [15:0] s_b [N];
  logic        s_c [N];
  logic [16:0] s_ap[N];

  logic [2:0]  e_cnt, p_cnt;
  logic [16:0] e_max, p_max;
  logic [18:0] e_sum, p_sum;

  // Reference: metrics straight from the definition of ED.
  task automatic model();
    int unsigned ex, ap, ed, mx, sm, ct;
    ct = 0; mx = 0; sm = 0;
    for (int i = 0; i < N; i++) begin
      ex = 32'(s_a[i]) + 32'(s_b[i]) + 32'(s_c[i]);
      ap = 32'(s_ap[i]);
      ed = (ex > ap) ? ex - ap : ap - ex;
      if (ed != 0) ct++;
      if (ed > mx) mx = ed;
      sm += ed;
    end
    e_cnt = 3'(ct);
    e_max = 17'(mx);
    e_sum = 19'(sm);
  endtask

  task automatic rand_data();
    bus.add1_i   = 16'($urandom);
    bus.add2_i   = 16'($urandom);
    bus.carry_i  = 1'($urandom);
    bus.approx_i = 17'($urandom);
  endtask

  task automatic set_all(input logic [15:0] a, input logic [15:0] b, input logic c);
    for (int i = 0; i < N; i++) begin
      s_a[i] = a; s_b[i] = b; s_c[i] = c;
    end
  endtask

  task automatic set_random();
    int unsigned ex;
    for (int i = 0; i < N; i++) begin
      s_a[i] = 16'($urandom); s_b[i] = 16'($urandom); s_c[i] = 1'($urandom);
      ex = 32'(s_a[i]) + 32'(s_b[i]) + 32'(s_c[i]);
      case ($urandom_range(2))
        0:       s_ap[i] = 17'(ex);
        1:       s_ap[i] = 17'(ex) ^ (17'd1 << $urandom_range(16));
        default: s_ap[i] = 17'($urandom);
      endcase
    end
  endtask

  // One full window; gaps adds idle/valid noise and a stray start in COLLECT,
  // b2b raises start while done_o is high.
  task automatic run_window(input bit gaps, input bit b2b, input string tag);
    int lat;
    model();
    if (gaps) begin
      @(negedge clk); rand_data(); bus.valid_i = 1'b1;
      @(negedge clk); bus.valid_i = 1'b0;
    end
    @(negedge clk); bus.start_i = 1'b1;
    @(negedge clk); bus.start_i = 1'b0;
    n_tests++;
    if (bus.busy_o !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_start: got %b exp 1", tag, bus.busy_o);
    end
    n_tests++;
    if ({bus.err_count_o, bus.max_ed_o, bus.sum_ed_o} !== {p_cnt, p_max, p_sum}) begin
      n_fail++;
      $display("FAIL %s hold: got %h/%h/%h exp %h/%h/%h", tag, bus.err_count_o,
               bus.max_ed_o, bus.sum_ed_o, p_cnt, p_max, p_sum);
    end
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        bus.valid_i = 1'b0; rand_data();
        if (i == 2) bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
      end
      bus.add1_i = s_a[i]; bus.add2_i = s_b[i]; bus.carry_i = s_c[i];
      bus.approx_i = s_ap[i]; bus.valid_i = 1'b1;
      @(negedge clk);
    end
    bus.valid_i = gaps;
    rand_data();
    lat = 0;
    while (bus.done_o !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
      bus.valid_i = gaps;
      rand_data();
    end
    bus.valid_i = 1'b0;
    n_tests++;
    if (lat != 3) begin
      n_fail++; $display("FAIL %s done_latency: got %0d exp 3", tag, lat);
    end
    n_tests++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_at_done: got %b exp 0", tag, bus.busy_o);
    end
    n_tests++;
    if (bus.err_count_o !== e_cnt) begin
      n_fail++; $display("FAIL %s err_count: got %h exp %h", tag, bus.err_count_o, e_cnt);
    end
    n_tests++;
    if (bus.max_ed_o !== e_max) begin
      n_fail++; $display("FAIL %s max_ed: got %h exp %h", tag, bus.max_ed_o, e_max);
    end
    n_tests++;
    if (bus.sum_ed_o !== e_sum) begin
      n_fail++; $display("FAIL %s sum_ed: got %h exp %h", tag, bus.sum_ed_o, e_sum);
    end
    if (b2b) bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    n_tests++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b exp 0/0", tag, bus.done_o, bus.busy_o);
    end
    p_cnt = e_cnt; p_max = e_max; p_sum = e_sum;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0; bus.valid_i = 1'b0; rand_data();
    p_cnt = '0; p_max = '0; p_sum = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.busy_o, bus.done_o, bus.err_count_o, bus.max_ed_o, bus.sum_ed_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b %h/%h/%h exp all 0", bus.busy_o,
               bus.done_o, bus.err_count_o, bus.max_ed_o, bus.sum_ed_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exact();
    set_all(16'h00FF, 16'h0001, 1'b0);
    for (int i = 0; i < N; i++) s_ap[i] = 17'h00100;
    run_window(1'b0, 1'b0, "exact");
  endtask

  task automatic test_errors();
    set_all(16'h00FF, 16'h0001, 1'b0);
    s_ap[0] = 17'h000FF; s_ap[1] = 17'h00100; s_ap[2] = 17'h0010F; s_ap[3] = 17'h00000;
    run_window(1'b0, 1'b0, "errors");
  endtask

  task automatic test_extreme();
    set_all(16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < N; i++) s_ap[i] = 17'h0;
    run_window(1'b0, 1'b0, "extreme");
  endtask

  task automatic test_gaps();
    set_random();
    run_window(1'b1, 1'b0, "gaps");
  endtask

  task automatic test_reset_mid();
    int seen_done;
    set_all(16'h1234, 16'h4321, 1'b1);
    @(negedge clk); bus.start_i = 1'b1;
    @(negedge clk); bus.start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_data(); bus.valid_i = 1'b1;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.busy_o, bus.done_o, bus.err_count_o, bus.max_ed_o, bus.sum_ed_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b %h/%h/%h exp all 0", bus.busy_o,
               bus.done_o, bus.err_count_o, bus.max_ed_o, bus.sum_ed_o);
    end
    @(negedge clk); rst = 1'b0;
    p_cnt = '0; p_max = '0; p_sum = '0;
    seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) seen_done++;
    end
    n_tests++;
    if (seen_done != 0) begin
      n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles exp 0", seen_done);
    end
    s_ap[0] = 17'h00000; s_ap[1] = 17'h05556; s_ap[2] = 17'h1FFFF; s_ap[3] = 17'h05555;
    run_window(1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    set_random();
    run_window(1'b0, 1'b1, "b2b_first");
    set_random();
    run_window(1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      set_random();
      run_window(1'(w & 1), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_errors();
    test_extreme();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
